// File: rtl/uart_cmd_receiver_pkg.sv
// Shared command constants and FSM encoding for the UART command link.
// The sender side uses the same nibbles, so keep them in sync with it.
// Optional ACK reply path: CMD_ACK_EN.
package uart_cmd_receiver_pkg;

  localparam logic [3:0] CMD_ON     = 4'h6;
  localparam logic [3:0] CMD_OFF    = 4'hD;
  localparam logic [3:0] CMD_TOGGLE = 4'h9;
  localparam logic [3:0] CMD_ACK    = 4'h0;

  localparam int         MARKER_BIT = 7;
  // Marker set, Hamming codeword of nibble 0 is all zeros.
  localparam logic [7:0] ACK_BYTE   = 8'h80;

`ifdef CMD_ACK_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_DECODE, ST_EXEC, ST_ACK_REQ, ST_ACK_WAIT
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE, ST_DECODE, ST_EXEC
  } state_e;
`endif

  function automatic logic is_valid_cmd(input logic [3:0] c);
    return (c == CMD_ON) || (c == CMD_OFF) || (c == CMD_TOGGLE) || (c == CMD_ACK);
  endfunction

endpackage

// File: rtl/uart_cmd_receiver_hamming.sv
// Hamming(7,4) single-error-correcting decoder, inverse of hamming_7_4_encoder.
// Bit i of the codeword is Hamming position i+1: (p0,p1,d0,p2,d1,d2,d3).
module hamming_7_4_decoder (
  input  logic [6:0] codeword_i,
  output logic [3:0] data_o,
  output logic [2:0] syndrome_o,
  output logic       corrected_o
);

  logic [2:0] syn;
  logic [6:0] fixed;

  // Syndrome points at the flipped position (1-based); zero means clean.
  always_comb begin
    syn[0] = codeword_i[0] ^ codeword_i[2] ^ codeword_i[4] ^ codeword_i[6];
    syn[1] = codeword_i[1] ^ codeword_i[2] ^ codeword_i[5] ^ codeword_i[6];
    syn[2] = codeword_i[3] ^ codeword_i[4] ^ codeword_i[5] ^ codeword_i[6];
    fixed  = codeword_i;
    for (int i = 0; i < 7; i++)
      if (syn == 3'(i + 1)) fixed[i] = ~codeword_i[i];
  end

  assign syndrome_o  = syn;
  assign corrected_o = |syn;
  assign data_o      = {fixed[6], fixed[5], fixed[4], fixed[2]};

endmodule

// File: rtl/uart_cmd_receiver.sv
// Command endpoint: frames, Hamming-decodes and executes ON/OFF/TOGGLE on out_en,
// with a silence watchdog and a saturating reject counter.
// Optional ACK reply to uart_tx: CMD_ACK_EN.
module uart_cmd_receiver
  import uart_cmd_receiver_pkg::*;
#(
  parameter int unsigned WDT_CYCLES = 48_000_000,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           rx_data,
  input  logic                 rx_done,
  input  logic                 rx_parity_err,
  output logic                 out_en,
  output logic                 cmd_valid,
  output logic [3:0]           cmd_code,
  output logic                 err_corrected,
  output logic                 err_reject,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 wdt_trip,
  output logic [7:0]           ack_data,
  output logic                 ack_start,
  input  logic                 ack_busy
);

  localparam int WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;

  state_e               state_q, state_d;
  logic [7:0]           byte_q, byte_d;
  logic                 perr_q, perr_d;
  logic                 ack_pend_q, ack_pend_d;
  logic                 out_en_q, out_en_d;
  logic [3:0]           code_q, code_d;
  logic                 valid_q, valid_d;
  logic                 corr_q, corr_d;
  logic                 rej_q, rej_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic                 trip_q, trip_d;
  logic [WDT_W-1:0]     wdt_q, wdt_d;
  logic                 ack_start_q, ack_start_d;
  logic [7:0]           ack_data_q, ack_data_d;

  logic [3:0]           dec_data;
  logic [2:0]           unused_syn;
  logic                 dec_corr;
  logic                 overrun, frame_ok, accept, dec_rej;
  logic [1:0]           n_err;
  logic [ERR_CNT_W:0]   err_sum;

  hamming_7_4_decoder u_dec (
    .codeword_i  (byte_q[6:0]),
    .data_o      (dec_data),
    .syndrome_o  (unused_syn),
    .corrected_o (dec_corr)
  );

  // Next-state, command execution, watchdog and counters.
  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    perr_d      = perr_q;
    ack_pend_d  = ack_pend_q;
    out_en_d    = out_en_q;
    code_d      = code_q;
    ack_start_d = 1'b0;
    ack_data_d  = ack_data_q;

    overrun  = rx_done && (state_q != ST_IDLE);
    frame_ok = byte_q[MARKER_BIT] && !perr_q;
    accept   = (state_q == ST_DECODE) && frame_ok && is_valid_cmd(dec_data);
    dec_rej  = (state_q == ST_DECODE) && !accept;

    case (state_q)
      ST_IDLE: if (rx_done) begin
        byte_d  = rx_data;
        perr_d  = rx_parity_err;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        ack_pend_d = accept && (dec_data != CMD_ACK);
        state_d    = ST_EXEC;
      end
`ifdef CMD_ACK_EN
      ST_EXEC: begin
        state_d = ack_pend_q ? ST_ACK_REQ : ST_IDLE;
        if (ack_pend_q) begin
          ack_start_d = 1'b1;
          ack_data_d  = ACK_BYTE;
        end
      end
      ST_ACK_REQ: begin
        ack_start_d = !ack_busy;
        if (ack_busy) state_d = ST_ACK_WAIT;
      end
      ST_ACK_WAIT: if (!ack_busy) state_d = ST_IDLE;
`else
      ST_EXEC: state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase

    // Watchdog: a command in the same cycle as a trip takes precedence.
    trip_d = (WDT_CYCLES != 0) && out_en_q && !accept &&
             (wdt_q == WDT_W'(WDT_CYCLES - 1));
    if (!out_en_q || accept || trip_d) wdt_d = '0;
    else                               wdt_d = wdt_q + WDT_W'(1);
    if (trip_d) out_en_d = 1'b0;

    if (accept) begin
      code_d = dec_data;
      case (dec_data)
        CMD_ON:     out_en_d = 1'b1;
        CMD_OFF:    out_en_d = 1'b0;
        CMD_TOGGLE: out_en_d = ~out_en_q;
        default:    out_en_d = out_en_q;
      endcase
    end

    valid_d = accept;
    corr_d  = (state_q == ST_DECODE) && frame_ok && dec_corr;
    rej_d   = overrun || dec_rej;

    // An overrun can coincide with a decode reject; both are counted.
    n_err   = {1'b0, overrun} + {1'b0, dec_rej};
    err_sum = {1'b0, err_q} + (ERR_CNT_W + 1)'(n_err);
    err_d   = err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      byte_q      <= '0;
      perr_q      <= 1'b0;
      ack_pend_q  <= 1'b0;
      out_en_q    <= 1'b0;
      code_q      <= '0;
      valid_q     <= 1'b0;
      corr_q      <= 1'b0;
      rej_q       <= 1'b0;
      err_q       <= '0;
      trip_q      <= 1'b0;
      wdt_q       <= '0;
      ack_start_q <= 1'b0;
      ack_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      perr_q      <= perr_d;
      ack_pend_q  <= ack_pend_d;
      out_en_q    <= out_en_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
      corr_q      <= corr_d;
      rej_q       <= rej_d;
      err_q       <= err_d;
      trip_q      <= trip_d;
      wdt_q       <= wdt_d;
      ack_start_q <= ack_start_d;
      ack_data_q  <= ack_data_d;
    end
  end

  assign out_en        = out_en_q;
  assign cmd_valid     = valid_q;
  assign cmd_code      = code_q;
  assign err_corrected = corr_q;
  assign err_reject    = rej_q;
  assign err_count     = err_q;
  assign wdt_trip      = trip_q;

`ifdef CMD_ACK_EN
  assign ack_start = ack_start_q;
  assign ack_data  = ack_data_q;
`else
  logic unused_ack;
  assign unused_ack = ack_busy ^ ack_start_q ^ (^ack_data_q);
  assign ack_start  = 1'b0;
  assign ack_data   = 8'h00;
`endif

endmodule

// File: tb/tb_uart_cmd_receiver.sv
// Directed bench for uart_cmd_receiver (WDT_CYCLES=100); ACK checks under CMD_ACK_EN.
module tb_uart_cmd_receiver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       rx_parity_err = 1'b0;
  logic       ack_busy = 1'b0;
  logic       out_en, cmd_valid, err_corrected, err_reject, wdt_trip, ack_start;
  logic [3:0] cmd_code;
  logic [7:0] err_count, ack_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_cmd_receiver #(.WDT_CYCLES(100), .ERR_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
    .rx_parity_err(rx_parity_err), .out_en(out_en), .cmd_valid(cmd_valid),
    .cmd_code(cmd_code), .err_corrected(err_corrected), .err_reject(err_reject),
    .err_count(err_count), .wdt_trip(wdt_trip), .ack_data(ack_data),
    .ack_start(ack_start), .ack_busy(ack_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One-cycle rx_done strobe; returns at the falling edge after capture.
  task automatic send(input logic [7:0] b, input logic perr);
    @(negedge clk);
    rx_data = b; rx_parity_err = perr; rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0; rx_parity_err = 1'b0;
  endtask

  // Cycle after the result pulses: pulses end, optional ACK handshake.
  task automatic tail(input string tag, input logic exp_ack);
    @(negedge clk);
    chk({tag, "_valid_end"}, cmd_valid, 0);
`ifdef CMD_ACK_EN
    chk({tag, "_ack_start"}, ack_start, exp_ack);
    if (exp_ack) begin
      chk({tag, "_ack_data"}, ack_data, 8'h80);
      ack_busy = 1'b1;
      @(negedge clk);
      chk({tag, "_ack_drop"}, ack_start, 0);
      ack_busy = 1'b0;
      @(negedge clk);
    end
`else
    chk({tag, "_ack_start"}, ack_start, 0);
    chk({tag, "_ack_data"}, ack_data, 0);
`endif
  endtask

  task automatic do_cmd(input string tag, input logic [7:0] b, input logic perr,
                        input logic exp_v, input logic exp_en, input logic [3:0] exp_code,
                        input logic exp_corr, input logic exp_ack);
    send(b, perr);
    chk({tag, "_early"}, cmd_valid | err_reject, 0);
    @(negedge clk);
    chk({tag, "_valid"}, cmd_valid, exp_v);
    chk({tag, "_reject"}, err_reject, !exp_v);
    chk({tag, "_out_en"}, out_en, exp_en);
    chk({tag, "_code"}, cmd_code, exp_code);
    chk({tag, "_corr"}, err_corrected, exp_corr);
    tail(tag, exp_ack);
  endtask

  initial begin
    int trip_n;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_en", out_en, 0);
    chk("rst_code", cmd_code, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_pulses", {cmd_valid, err_corrected, err_reject, wdt_trip}, 0);
    chk("rst_ack", {ack_start, ack_data}, 0);
    reset = 1'b0;

    // ON, OFF, TOGGLE, TOGGLE
    do_cmd("on", 8'hB3, 0, 1, 1, 4'h6, 0, 1);
    do_cmd("off", 8'hE6, 0, 1, 0, 4'hD, 0, 1);
    do_cmd("tog1", 8'hCC, 0, 1, 1, 4'h9, 0, 1);
    do_cmd("tog2", 8'hCC, 0, 1, 0, 4'h9, 0, 1);
    chk("seq_err_count", err_count, 0);

    // Single-bit error in data bit d1 is corrected
    do_cmd("corr", 8'hA3, 0, 1, 1, 4'h6, 1, 1);

    // Rejects: marker clear, parity error, invalid nibble 3
    do_cmd("rej_marker", 8'h33, 0, 0, 1, 4'h6, 0, 0);
    do_cmd("rej_parity", 8'hB3, 1, 0, 1, 4'h6, 0, 0);
    do_cmd("rej_code3", 8'h9E, 0, 0, 1, 4'h6, 0, 0);
    chk("rej_err_count", err_count, 3);

    // Code 0: no-op, valid, no ACK
    do_cmd("noop", 8'h80, 0, 1, 1, 4'h0, 0, 0);

    // Overrun: second byte arrives while the first is being decoded
    @(negedge clk);
    rx_data = 8'hE6; rx_done = 1'b1;
    @(negedge clk);
    rx_data = 8'hB3;
    @(negedge clk);
    rx_done = 1'b0;
    chk("ovr_valid", cmd_valid, 1);
    chk("ovr_reject", err_reject, 1);
    chk("ovr_out_en", out_en, 0);
    chk("ovr_code", cmd_code, 4'hD);
    chk("ovr_err_count", err_count, 4);
    tail("ovr", 1);

    // Watchdog: trip 100 cycles after cmd_valid
    send(8'hB3, 0);
    @(negedge clk);
    chk("wdt_valid", cmd_valid, 1);
    trip_n = -1;
    for (int n = 1; n <= 150; n++) begin
      @(negedge clk);
      if (n == 1) ack_busy = 1'b1;
      if (n == 2) ack_busy = 1'b0;
      if (n == 99) chk("wdt_pre_out_en", out_en, 1);
      if (wdt_trip) begin trip_n = n; break; end
    end
    chk("wdt_trip_cycle", trip_n, 100);
    chk("wdt_out_en", out_en, 0);
    @(negedge clk);
    chk("wdt_trip_end", wdt_trip, 0);

    // Stalled ACK, dropped byte, reset mid-operation
    send(8'hB3, 0);
    @(negedge clk);
    chk("stall_out_en", out_en, 1);
`ifdef CMD_ACK_EN
    @(negedge clk);
    chk("stall_ack_rise", ack_start, 1);
    repeat (25) @(negedge clk);
    send(8'hCC, 0);
    chk("stall_drop_reject", err_reject, 1);
    chk("stall_drop_count", err_count, 5);
    repeat (25) @(negedge clk);
    chk("stall_ack_held", ack_start, 1);
    chk("stall_out_en_kept", out_en, 1);
`endif
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_out_en", out_en, 0);
    chk("midrst_ack", ack_start, 0);
    chk("midrst_err_count", err_count, 0);
    @(negedge clk);
    reset = 1'b0;

    // Error counter saturates at all-ones
    for (int i = 0; i < 260; i++) begin
      send(8'h33, 0);
      @(negedge clk);
    end
    @(negedge clk);
    chk("sat_err_count", err_count, 8'hFF);
    chk("sat_out_en", out_en, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
